// File: rtl/expr_bus_pkg.sv
// Shared definitions for the 90-bit packed expression-result bus:
// bus geometry, per-position field table and the reader FSM states.
package expr_bus_pkg;

    localparam int unsigned EXPR_BUS_W   = 90;
    localparam int unsigned EXPR_NFIELDS = 18;

    // Per-position (k = idx mod 6) width, offset in the 30-bit group, signedness
    localparam int unsigned FIELD_W      [6] = '{4, 5, 6, 4, 5, 6};
    localparam int unsigned FIELD_OFF    [6] = '{0, 4, 9, 15, 19, 24};
    localparam bit          FIELD_SIGNED [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    typedef logic [4:0] field_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        SIG
    } state_t;

endpackage

// File: rtl/expr_field_extract.sv
// Combinational selection of field idx_i from the packed vector,
// zero- or sign-extended to OUT_W according to its group position.
module expr_field_extract
    import expr_bus_pkg::*;
#(
    parameter int unsigned OUT_W = 8
) (
    input  logic [EXPR_BUS_W-1:0] vec_i,
    input  field_idx_t            idx_i,
    output logic [OUT_W-1:0]      field_o
);

    logic [2:0]  k;
    logic [2:0]  g;
    int unsigned lsb;
    logic [5:0]  raw;
    logic        sign;

    always_comb begin
        k    = 3'(idx_i % 5'd6);
        g    = 3'(idx_i / 5'd6);
        // Field LSB = MSB - width + 1, with MSB = 89 - 30*g - offset
        lsb  = EXPR_BUS_W - 32'd30 * 32'(g) - FIELD_OFF[k] - FIELD_W[k];
        raw  = '0;
        for (int unsigned b = 0; b < 6; b++) begin
            if (b < FIELD_W[k]) begin
                raw[b] = vec_i[7'(lsb + b)];
            end
        end
        sign    = FIELD_SIGNED[k] & raw[3'(FIELD_W[k] - 1)];
        field_o = '0;
        if (32'(idx_i) < EXPR_NFIELDS) begin
            for (int unsigned b = 0; b < OUT_W; b++) begin
                field_o[b] = (b < FIELD_W[k]) ? raw[3'(b)] : sign;
            end
        end
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Reader for the packed expression-result bus: captures one vector, emits its
// 18 extended fields with handshake, then pulses a 16-bit rotate/xor signature.
module expr_result_unpacker
    import expr_bus_pkg::*;
#(
    parameter int unsigned OUT_W    = 8,
    parameter logic [15:0] SIG_SEED = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXPR_BUS_W-1:0] in_data,
    output logic                  field_valid,
    input  logic                  field_ready,
    output logic [4:0]            field_idx,
    output logic [OUT_W-1:0]      field_data,
    output logic                  field_last,
    output logic                  sig_valid,
    output logic [15:0]           sig_data
);

    localparam int unsigned FOLD_W = (OUT_W < 16) ? OUT_W : 16;
    localparam field_idx_t  LAST_IDX = field_idx_t'(EXPR_NFIELDS - 1);

    state_t                state_q, state_d;
    logic [EXPR_BUS_W-1:0] vec_q, vec_d;
    field_idx_t            idx_q, idx_d;
    logic [15:0]           sig_q, sig_d;
    logic [15:0]           sig_out_q, sig_out_d;
    logic [OUT_W-1:0]      ext;
    logic [15:0]           fold;
    logic [15:0]           sig_next;

    expr_field_extract #(.OUT_W(OUT_W)) u_extract (
        .vec_i   (vec_q),
        .idx_i   (idx_q),
        .field_o (ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            idx_q     <= '0;
            sig_q     <= '0;
            sig_out_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            idx_q     <= idx_d;
            sig_q     <= sig_d;
            sig_out_q <= sig_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        idx_d     = idx_q;
        sig_d     = sig_q;
        sig_out_d = sig_out_q;
        fold      = 16'(ext[FOLD_W-1:0]);
        sig_next  = {sig_q[14:0], sig_q[15]} ^ fold;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = in_data;
                    sig_d   = SIG_SEED;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (field_ready) begin
                    sig_d = sig_next;
                    if (idx_q == LAST_IDX) begin
                        sig_out_d = sig_next;
                        idx_d     = '0;
                        state_d   = SIG;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            SIG:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        field_valid = (state_q == EMIT);
        field_idx   = (state_q == EMIT) ? idx_q : '0;
        field_data  = (state_q == EMIT) ? ext : '0;
        field_last  = (state_q == EMIT) && (idx_q == LAST_IDX);
        sig_valid   = (state_q == SIG);
        sig_data    = sig_out_q;
    end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed bench for expr_result_unpacker: hand-computed field values and
// signatures, backpressure, mid-vector reset and back-to-back vectors.
module tb_expr_result_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_data;
    logic        field_valid;
    logic        field_ready;
    logic [4:0]  field_idx;
    logic [7:0]  field_data;
    logic        field_last;
    logic        sig_valid;
    logic [15:0] sig_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_f [18];

    always #5 clk = ~clk;

    expr_result_unpacker #(.OUT_W(8), .SIG_SEED(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .field_idx   (field_idx),
        .field_data  (field_data),
        .field_last  (field_last),
        .sig_valid   (sig_valid),
        .sig_data    (sig_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 18; i++) exp_f[i] = 8'h00;
    endtask

    task automatic check_idle();
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_field_valid", 32'(field_valid), 32'd0);
        chk("idle_field_idx", 32'(field_idx), 32'd0);
        chk("idle_field_data", 32'(field_data), 32'd0);
        chk("idle_field_last", 32'(field_last), 32'd0);
        chk("idle_sig_valid", 32'(sig_valid), 32'd0);
    endtask

    // Presents data, walks all 18 beats and checks the signature cycle.
    // keep_valid leaves in_valid high with next_data for back-to-back tests;
    // expect_now requires the handshake on the very first negedge.
    task automatic run_vec(input logic [89:0] data, input bit rnd_ready,
                           input logic [15:0] exp_sig, input bit keep_valid,
                           input logic [89:0] next_data, input bit expect_now);
        int unsigned wait_cyc = 0;
        int unsigned e = 0;
        int unsigned cyc = 0;
        logic rdy;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        while (!in_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (expect_now) chk("accept_latency", wait_cyc, 32'd0);
        if (!in_ready) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = keep_valid;
        in_data  = next_data;
        while (e < 18 && cyc < 400) begin
            chk("beat_valid", 32'(field_valid), 32'd1);
            chk("beat_in_ready", 32'(in_ready), 32'd0);
            chk("beat_idx", 32'(field_idx), e);
            chk("beat_data", 32'(field_data), 32'(exp_f[e]));
            chk("beat_last", 32'(field_last), (e == 17) ? 32'd1 : 32'd0);
            chk("beat_sig_valid", 32'(sig_valid), 32'd0);
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            field_ready = rdy;
            if (rdy) e++;
            @(negedge clk);
            cyc++;
        end
        if (e < 18) chk("beat_timeout", 32'd0, 32'd1);
        field_ready = 1'b1;
        chk("sig_valid", 32'(sig_valid), 32'd1);
        chk("sig_data", 32'(sig_data), 32'(exp_sig));
        chk("sig_in_ready", 32'(in_ready), 32'd0);
        chk("sig_field_valid", 32'(field_valid), 32'd0);
    endtask

    logic [89:0] v_zero, v_y0f, v_y35, v_y08;

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        field_ready = 1'b1;
        v_zero = '0;
        v_y0f  = '0; v_y0f[89:86] = 4'hF;
        v_y35  = '0; v_y35[74:71] = 4'h8; v_y35[65:60] = 6'h20;
        v_y08  = '0; v_y08[89:86] = 4'h8;

        repeat (2) @(negedge clk);
        check_idle();
        chk("reset_sig_data", 32'(sig_data), 32'd0);
        reset = 1'b0;

        // 1: all-zero vector
        clear_exp();
        run_vec(v_zero, 1'b0, 16'h0000, 1'b0, '0, 1'b0);
        @(negedge clk); check_idle();
        chk("hold_sig_data", 32'(sig_data), 32'h0000);

        // 2: y0 = F unsigned
        clear_exp(); exp_f[0] = 8'h0F;
        run_vec(v_y0f, 1'b0, 16'h001E, 1'b0, '0, 1'b0);
        @(negedge clk); check_idle();
        chk("hold_sig_data", 32'(sig_data), 32'h001E);

        // 3: signed fields y3 / y5, then unsigned y0 = 8
        clear_exp(); exp_f[3] = 8'hF8; exp_f[5] = 8'hE0;
        run_vec(v_y35, 1'b0, 16'h0030, 1'b0, '0, 1'b0);
        clear_exp(); exp_f[0] = 8'h08;
        run_vec(v_y08, 1'b0, 16'h0010, 1'b0, '0, 1'b0);

        // 4: random backpressure on scenario 2
        clear_exp(); exp_f[0] = 8'h0F;
        run_vec(v_y0f, 1'b1, 16'h001E, 1'b0, '0, 1'b0);

        // 5: reset while field 7 is presented
        @(negedge clk);
        in_valid = 1'b1; in_data = v_y0f;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !(field_valid && field_idx == 5'd7); i++) @(negedge clk);
        chk("pre_reset_idx", 32'(field_idx), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle();
        chk("abort_sig_data", 32'(sig_data), 32'd0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (sig_valid) chk("abort_no_sig", 32'(sig_valid), 32'd0);
        end
        clear_exp();
        run_vec(v_zero, 1'b0, 16'h0000, 1'b0, '0, 1'b0);

        // 6: back-to-back with in_valid held high
        clear_exp(); exp_f[0] = 8'h0F;
        run_vec(v_y0f, 1'b0, 16'h001E, 1'b1, v_y08, 1'b0);
        clear_exp(); exp_f[0] = 8'h08;
        run_vec(v_y08, 1'b0, 16'h0010, 1'b0, '0, 1'b1);
        @(negedge clk); check_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/expr_result_unpacker.md
Name: expr_result_unpacker

Overview:
- Consumer ("reader") side of the 90-bit packed expression-result bus produced by the vloghammer expression blocks.
- Accepts one packed vector per handshake and walks its 18 fields in order y0..y17, one field per accepted output beat.
- Extends each field to a fixed output width, signed or unsigned according to its position, and folds every field into a 16-bit signature.
- Sits between the device-under-test result bus and the regression scoreboard.

Parameters:
- OUT_W, 8: output field width; legal range is 6 or more. Fields are zero- or sign-extended to this width.
- SIG_SEED, 16'h0000: signature value loaded at the start of each vector.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  packed vector is valid.
- in_ready  out  1  block can accept a vector; high only in IDLE.
- in_data  in  90  packed vector {y0,...,y17}; y0 occupies [89:86].
- field_valid  out  1  a field is presented.
- field_ready  in  1  the consumer accepts the presented field.
- field_idx  out  5  field index, 0..17.
- field_data  out  OUT_W  extended field value.
- field_last  out  1  high together with field_idx==17.
- sig_valid  out  1  single-cycle pulse; sig_data is valid.
- sig_data  out  16  signature of the completed vector.

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready=1; field_valid=0, field_idx=0, field_data=0, field_last=0.
  - sig_valid=0; sig_data=0.
  - Captured vector register cleared.
- Field layout:
  - i = field index, k = i mod 6, g = i div 6.
  - Widths for k=0..5: 4,5,6,4,5,6.
  - k=0..2 are unsigned (zero-extend); k=3..5 are signed (sign-extend from the field MSB).
  - Offsets within a group for k=0..5: 0,4,9,15,19,24. Each group is 30 bits.
  - Field MSB bit = 89 - 30*g - offset(k).
  - The width and signedness table is a constant, not computed at run time.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data, set signature to SIG_SEED, set idx=0, go to EMIT.
  - The first field_valid appears the next cycle, so latency from handshake to first field is 1 cycle.
- State EMIT:
  - field_valid=1 and in_ready=0.
  - field_idx, field_data and field_last are registered values, or a pure function of registered state; they stay stable while field_valid&&!field_ready.
  - On field_valid&&field_ready: sig <= {sig[14:0],sig[15]} ^ {{(16-OUT_W){1'b0}}, field_data[OUT_W-1:0]}, truncated to 16 bits when OUT_W>16.
  - On the same accepted beat: if idx==17 go to SIG, otherwise idx <= idx+1.
  - Stalls of any length are allowed; nothing is dropped or duplicated.
- State SIG:
  - sig_valid=1 for exactly one cycle, with sig_data equal to the final signature.
  - sig_data holds its value until the next SIG state.
  - There is no backpressure on sig_valid.
  - Next state is IDLE, so the next vector can be accepted one cycle after the sig_valid pulse.
- Minimum spacing is 20 cycles per vector (1 capture, 18 fields, 1 signature).
- in_data changing while not in IDLE has no effect.
- Reset asserted mid-vector aborts the vector:
  - No sig_valid pulse for it.
  - All outputs return to reset values in the next cycle.
- reset wins over every other input in the same cycle.

Decomposition:
- Shared package expr_bus_pkg holds:
  - EXPR_BUS_W=90 and EXPR_NFIELDS=18.
  - Constant arrays FIELD_W[6] and FIELD_OFF[6], plus FIELD_SIGNED[6].
  - typedef field_idx_t (5 bits).
  - State enum {IDLE, EMIT, SIG}.
- One sub-module expr_field_extract: combinational; inputs are the vector and idx, output is the OUT_W extended field.
- The FSM, signature logic and handshakes remain in the top module.

Test Plan:
1. All-zero vector, field_ready tied 1 -> 18 beats with field_data=0x00 and idx 0..17; field_last only on idx 17; then sig_valid with sig_data=0x0000.
2. in_data[89:86]=4'hF, all other bits 0 -> field 0 = 0x0F; sig_data=0x001E (0x000F rotated left 17 times).
3. y3 bits [74:71]=4'h8 and y5 bits [65:60]=6'h20, rest 0 -> field 3 = 0xF8 and field 5 = 0xE0; y0 set to 4'h8 in a separate run gives field 0 = 0x08 (unsigned).
4. Backpressure: field_ready toggles with a random 50% pattern -> the output sequence is identical to scenario 2, with outputs stable during stalls and the same sig_data.
5. Reset pulsed at idx 7 -> no sig_valid pulse; next cycle in_ready=1 and field_valid=0; a following all-zero vector behaves as in scenario 1.
6. Back-to-back: in_valid held high with two vectors -> the second is accepted the cycle after the first sig_valid pulse; in_ready is low throughout EMIT.
